// File: rtl/fas.sv
// Registered 1-bit full adder / full subtractor.
// a_ns selects the operation: 1 = a+b+cin, 0 = a-b-cin (cin acts as borrow-in).
// s and cout come straight from flops; reset is synchronous and active-high.
module fas (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic sum_next;
    logic carry_add;
    logic borrow_sub;

    // Next-state arithmetic: the sum/difference bit is shared, only the carry term differs by mode
    always_comb begin
        sum_next   = a ^ b ^ cin;
        carry_add  = (a & b) | (a & cin) | (b & cin);
        borrow_sub = (~a & b) | (~a & cin) | (b & cin);
    end

    // Output registers; reset wins over the arithmetic update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= 1'b0;
            cout <= 1'b0;
        end else begin
            s    <= sum_next;
            cout <= a_ns ? carry_add : borrow_sub;
        end
    end

endmodule

// File: tb/tb_fas.sv
// Directed testbench for fas with a scoreboard queue of expected {cout,s}.
module tb_fas;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic a_ns;
    logic s;
    logic cout;

    int tests_run;
    int tests_failed;

    logic [1:0] sb[$];
    logic [1:0] last_exp;
    logic       have_last;
    logic [1:0] exp_v;

    fas dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .a_ns (a_ns),
        .s    (s),
        .cout (cout)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour from integer arithmetic, returns {cout,s}
    function automatic logic [1:0] model(input logic r, input logic ia, input logic ib,
                                         input logic ic, input logic m);
        int d;
        logic [1:0] res;
        if (r) begin
            res = 2'b00;
        end else if (m) begin
            d   = int'(ia) + int'(ib) + int'(ic);
            res = d[1:0];
        end else begin
            d   = int'(ia) - int'(ib) - int'(ic);
            res = {(d < 0), d[0]};
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] want);
        tests_run++;
        assert (got === want) else begin
            tests_failed++;
            $error("FAIL %s: observed {cout,s}=%b expected %b", tag, got, want);
        end
    endtask

    // Apply one input vector between edges, then compare one edge later
    task automatic step(input string tag, input logic r, input logic ia, input logic ib,
                        input logic ic, input logic m);
        @(negedge clk);
        rst  = r;
        a    = ia;
        b    = ib;
        cin  = ic;
        a_ns = m;
        sb.push_back(model(r, ia, ib, ic, m));
        #1;
        if (have_last) check({tag, "_hold"}, {cout, s}, last_exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s_sb: observed empty queue expected one entry", tag);
        end else begin
            exp_v = sb.pop_front();
            check(tag, {cout, s}, exp_v);
            last_exp  = exp_v;
            have_last = 1'b1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        have_last    = 1'b0;
        last_exp     = 2'b00;
        rst  = 1'b1;
        a    = 1'b1;
        b    = 1'b1;
        cin  = 1'b1;
        a_ns = 1'b1;

        // Reset held with all operands high
        step("reset0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("reset1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // First edge out of reset, then 0-1 borrow
        step("sub_first", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sub_0m1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Add sweep with a one-edge reset inserted at 111
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            if (i == 7) step("add_midrst", 1'b1, v[2], v[1], v[0], 1'b1);
            step($sformatf("add_%0d", i), 1'b0, v[2], v[1], v[0], 1'b1);
        end

        // Subtract sweep
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            step($sformatf("sub_%0d", i), 1'b0, v[2], v[1], v[0], 1'b0);
        end

        // Mode toggle with a=b=1, cin=0
        step("tog_add0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("tog_sub",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("tog_add1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset pulse between edges must not disturb the registered outputs
        rst = 1'b1;
        #2;
        check("rst_async_rise", {cout, s}, last_exp);
        rst = 1'b0;
        #1;
        check("rst_async_fall", {cout, s}, last_exp);

        // Reset asserted at an edge clears, then arithmetic resumes
        step("rst_again", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("resume",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        tests_run++;
        assert (sb.size() == 0) else begin
            tests_failed++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
